// File: rtl/bch_stim_pkg.sv
// Shared definitions for the BCH link exerciser: LFSR polynomial, the
// generator FSM state type and a width helper used for the derived
// nerr / draw / index field widths.
package bch_stim_pkg;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        GEN_DATA,
        GEN_NERR,
        GEN_ERR,
        READY
    } stim_state_t;

    // Number of bits needed to encode values 0..v-1, never less than 1.
    function automatic int bits_for(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bch_stim_lfsr.sv
// 32-bit right-shifting Galois LFSR. bit_out is bit 0 of the value the
// register takes on this edge, so the consumer sees the post-step bit in
// the same cycle that it asserts step.
module bch_stim_lfsr
    import bch_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    output logic bit_out
);

    logic [31:0] lfsr;
    logic [31:0] lfsr_next;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & LFSR_POLY);
    assign bit_out   = lfsr_next[0];

    // Advance the sequence only while the generator is consuming bits.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/bch_stim_check.sv
// BCH link exerciser: builds a random message and a random 0..T-bit error
// pattern in shadow registers, hands them to the encoder/channel on
// load_req, remembers each sent message in a small FIFO and checks every
// decoded word against it.
// Optional feature: define BCH_STIM_COUNTERS_EN to build the frames and
// mismatches counters; otherwise both ports read as zero.
module bch_stim_check
    import bch_stim_pkg::*;
#(
    parameter int          N     = 31,
    parameter int          K     = 11,
    parameter int          T     = 5,
    parameter logic [31:0] SEED  = 32'h1,
    parameter int          DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_req,
    output logic [K-1:0]             din,
    output logic [bits_for(T+2)-1:0] nerr,
    output logic [N-1:0]             error,
    input  logic                     vdout,
    input  logic [K-1:0]             dout,
    output logic                     wrong_now,
    output logic                     wrong,
    output logic                     starve,
    output logic                     ovf,
    output logic [31:0]              frames,
    output logic [15:0]              mismatches
);

    localparam int NW = bits_for(T + 2);   // nerr width
    localparam int DW = bits_for(T + 1);   // bits per nerr draw
    localparam int IW = bits_for(N);       // bits per error index draw
    localparam int RW = (DW > IW) ? DW : IW;
    localparam int CW = bits_for(K);
    localparam int AW = bits_for(DEPTH);

    stim_state_t   state;
    logic [K-1:0]  sh_data;
    logic [NW-1:0] sh_nerr;
    logic [N-1:0]  sh_err;
    logic [RW-2:0] draw;
    logic [RW-1:0] draw_next;
    logic [DW-1:0] nerr_cand;
    logic [IW-1:0] idx_cand;
    logic          nerr_ok;
    logic          idx_ok;
    logic [CW-1:0] cnt;
    logic [NW-1:0] ecnt;
    logic          pending;
    logic          gen_step;
    logic          lfsr_bit;

    logic [K-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;
    logic          load;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;
    logic          mismatch;

    assign gen_step = (state != READY);

    bch_stim_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step    (gen_step),
        .bit_out (lfsr_bit)
    );

    // Candidate draws: the last DW / IW bits shifted in, oldest bit at the MSB.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        draw_next = {draw, lfsr_bit};
        nerr_cand = draw_next[DW-1:0];
        idx_cand  = draw_next[IW-1:0];
        nerr_ok   = (nerr_cand <= DW'(T));
        idx_ok    = ({1'b0, idx_cand} < (IW + 1)'(N)) && !sh_err[idx_cand];
    end

    assign load     = (state == READY) && (load_req || pending);
    assign empty    = (fill == '0);
    assign full     = (fill == (AW + 1)'(DEPTH));
    assign do_pop   = vdout && !empty;
    assign do_push  = load && (!full || do_pop);
    assign mismatch = vdout && (empty || (dout != mem[rd_ptr]));

    // Generator FSM: fills shadow registers bit by bit, publishes them on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= GEN_DATA;
            sh_data <= '0;
            sh_nerr <= '0;
            sh_err  <= '0;
            draw    <= '0;
            cnt     <= '0;
            ecnt    <= '0;
            pending <= 1'b0;
            starve  <= 1'b0;
            din     <= '0;
            nerr    <= '0;
            error   <= '0;
        end else begin
            if (gen_step) begin
                draw <= draw_next[RW-2:0];
                if (load_req) begin
                    starve  <= 1'b1;
                    pending <= 1'b1;
                end
            end
            case (state)
                GEN_DATA: begin
                    sh_data <= {sh_data[K-2:0], lfsr_bit};
                    if (cnt == CW'(K - 1)) begin
                        cnt   <= '0;
                        state <= GEN_NERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GEN_NERR: begin
                    if (cnt == CW'(DW - 1)) begin
                        cnt <= '0;
                        if (nerr_ok) begin
                            sh_nerr <= NW'(nerr_cand);
                            ecnt    <= '0;
                            state   <= (nerr_cand == '0) ? READY : GEN_ERR;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GEN_ERR: begin
                    if (cnt == CW'(IW - 1)) begin
                        cnt <= '0;
                        if (idx_ok) begin
                            sh_err[idx_cand] <= 1'b1;
                            ecnt             <= ecnt + NW'(1);
                            if (ecnt + NW'(1) == sh_nerr) state <= READY;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                READY: begin
                    if (load) begin
                        din     <= sh_data;
                        nerr    <= sh_nerr;
                        error   <= sh_err;
                        sh_err  <= '0;
                        pending <= 1'b0;
                        state   <= GEN_DATA;
                    end
                end
                default: state <= GEN_DATA;
            endcase
        end
    end

    // FIFO bookkeeping, overflow flag and the registered mismatch pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            ovf       <= 1'b0;
            wrong_now <= 1'b0;
            wrong     <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + (AW + 1)'(1);
                2'b01:   fill <= fill - (AW + 1)'(1);
                default: fill <= fill;
            endcase
            if (load && !do_push) ovf <= 1'b1;
            wrong_now <= mismatch;
            if (mismatch) wrong <= 1'b1;
        end
    end

    // Expected-word storage; a read on a full-and-pushing cycle sees the old entry.
    // NOTE: storage is not reset; fill alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= sh_data;
    end

`ifdef BCH_STIM_COUNTERS_EN
    // Frame counter wraps; mismatch counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames     <= '0;
            mismatches <= '0;
        end else begin
            if (vdout) frames <= frames + 32'd1;
            if (mismatch && (mismatches != 16'hFFFF)) mismatches <= mismatches + 16'd1;
        end
    end
`else
    assign frames     = '0;
    assign mismatches = '0;
`endif

endmodule

// File: tb/tb_bch_stim_check.sv
// Self-checking bench for bch_stim_check. A reference model replays the
// LFSR bit stream to predict every message, error count and error pattern
// (and how many cycles each takes to build); expected words and expected
// wrong_now values go through queues and are compared when the DUT responds.
module tb_bch_stim_check;

    localparam int          N     = 31;
    localparam int          K     = 11;
    localparam int          T     = 5;
    localparam int          DEPTH = 4;
    localparam logic [31:0] SEED  = 32'h1;
    localparam logic [31:0] POLY  = 32'h80200003;
    localparam int          W     = 3;   // bits per nerr draw
    localparam int          IW    = 5;   // bits per index draw
`ifdef BCH_STIM_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [K-1:0] d;
        logic [2:0]   ne;
        logic [N-1:0] e;
        int           len;   // generation cycles for this word
        int           pre;   // cycles before the error-pattern phase
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic          vdout = 1'b0;
    logic [K-1:0]  dout = '0;
    logic [K-1:0]  din;
    logic [2:0]    nerr;
    logic [N-1:0]  error;
    logic          wrong_now;
    logic          wrong;
    logic          starve;
    logic          ovf;
    logic [31:0]   frames;
    logic [15:0]   mismatches;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   m_lfsr;
    word_t         nxt;
    word_t         exp_q[$];
    logic          wn_q[$];
    logic [K-1:0]  sent_q[$];

    bch_stim_check #(.N(N), .K(K), .T(T), .SEED(SEED), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .din        (din),
        .nerr       (nerr),
        .error      (error),
        .vdout      (vdout),
        .dout       (dout),
        .wrong_now  (wrong_now),
        .wrong      (wrong),
        .starve     (starve),
        .ovf        (ovf),
        .frames     (frames),
        .mismatches (mismatches)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
    endfunction

    // Model of one generated word, consuming the shared bit stream.
    task automatic m_gen(output word_t w);
        logic [2:0] v;
        logic [4:0] idx;
        int c;
        w.d = '0; w.ne = '0; w.e = '0; w.len = 0; w.pre = 0;
        for (int i = 0; i < K; i++) begin
            m_lfsr = m_step(m_lfsr);
            w.d = {w.d[K-2:0], m_lfsr[0]};
            w.len++;
        end
        do begin
            v = '0;
            for (int i = 0; i < W; i++) begin
                m_lfsr = m_step(m_lfsr);
                v = {v[1:0], m_lfsr[0]};
                w.len++;
            end
        end while (v > 3'(T));
        w.ne  = v;
        w.pre = w.len;
        c = 0;
        while (c < int'(w.ne)) begin
            idx = '0;
            for (int i = 0; i < IW; i++) begin
                m_lfsr = m_step(m_lfsr);
                idx = {idx[3:0], m_lfsr[0]};
                w.len++;
            end
            if (int'(idx) < N && !w.e[idx]) begin
                w.e[idx] = 1'b1;
                c++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset, restart the model from SEED and wait until word 0 is ready.
    task automatic do_reset();
        reset = 1'b1;
        #3;
        ticks(2);
        reset = 1'b0;
        m_lfsr = SEED;
        m_gen(nxt);
        exp_q.delete();
        wn_q.delete();
        sent_q.delete();
        ticks(nxt.len + 2);
    endtask

    // Pulse load_req (optionally with a simultaneous vdout) and check the
    // published word against the model's prediction.
    task automatic load_word(input bit pop, input logic [K-1:0] pd, input bit pop_wn,
                             output word_t w);
        logic e_wn;
        exp_q.push_back(nxt);
        load_req = 1'b1;
        if (pop) begin
            vdout = 1'b1;
            dout  = pd;
            wn_q.push_back(pop_wn);
        end
        tick();
        load_req = 1'b0;
        vdout    = 1'b0;
        w = exp_q.pop_front();
        checks++;
        if (din !== w.d) begin
            errors++;
            $display("FAIL din: got %0h, expected %0h", din, w.d);
        end
        checks++;
        if (nerr !== w.ne) begin
            errors++;
            $display("FAIL nerr: got %0d, expected %0d", nerr, w.ne);
        end
        checks++;
        if (error !== w.e) begin
            errors++;
            $display("FAIL error: got %0h, expected %0h", error, w.e);
        end
        if (pop) begin
            e_wn = wn_q.pop_front();
            checks++;
            if (wrong_now !== e_wn) begin
                errors++;
                $display("FAIL push_pop_wrong_now: got %0b, expected %0b", wrong_now, e_wn);
            end
        end
        m_gen(nxt);
    endtask

    // One decoded word: drive vdout for a cycle and check the wrong_now pulse.
    task automatic send_vdout(input logic [K-1:0] d, input bit exp_wn);
        logic e_wn;
        vdout = 1'b1;
        dout  = d;
        wn_q.push_back(exp_wn);
        tick();
        vdout = 1'b0;
        e_wn = wn_q.pop_front();
        checks++;
        if (wrong_now !== e_wn) begin
            errors++;
            $display("FAIL wrong_now: got %0b, expected %0b (dout %0h)", wrong_now, e_wn, d);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({din, nerr, error, wrong_now, wrong, starve, ovf, frames, mismatches} !== '0) begin
            errors++;
            $display("FAIL reset_state: got din=%0h nerr=%0d error=%0h flags=%b%b%b%b frames=%0d mism=%0d, expected all 0",
                     din, nerr, error, wrong_now, wrong, starve, ovf, frames, mismatches);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        send_vdout('0, 1'b1);
        checks++;
        if (wrong !== 1'b1) begin
            errors++;
            $display("FAIL underflow_wrong: got %0b, expected 1", wrong);
        end
        checks++;
        if (frames !== (CNT_EN ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL underflow_frames: got %0d, expected %0d", frames, CNT_EN ? 1 : 0);
        end
        checks++;
        if (mismatches !== (CNT_EN ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL underflow_mismatches: got %0d, expected %0d", mismatches, CNT_EN ? 1 : 0);
        end
        tick();
        checks++;
        if (wrong_now !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pulse_width: got %0b, expected 0", wrong_now);
        end
    endtask

    // Loopback with dout = din three cycles later; flip_at selects a corrupted word.
    task automatic test_loopback(input int nwords, input int flip_at);
        word_t w;
        logic [K-1:0] d;
        do_reset();
        for (int i = 0; i < nwords; i++) begin
            load_word(1'b0, '0, 1'b0, w);
            sent_q.push_back(w.d);
            ticks(2);
            d = sent_q.pop_front();
            if (i == flip_at) d[0] = ~d[0];
            send_vdout(d, i == flip_at);
            ticks(nxt.len - 1);
        end
        checks++;
        if (wrong !== (flip_at >= 0)) begin
            errors++;
            $display("FAIL loop_wrong: got %0b, expected %0b", wrong, flip_at >= 0);
        end
        checks++;
        if (frames !== (CNT_EN ? 32'(nwords) : 32'd0)) begin
            errors++;
            $display("FAIL loop_frames: got %0d, expected %0d", frames, CNT_EN ? nwords : 0);
        end
        checks++;
        if (mismatches !== ((CNT_EN && flip_at >= 0) ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL loop_mismatches: got %0d, expected %0d", mismatches,
                     (CNT_EN && flip_at >= 0) ? 1 : 0);
        end
        checks++;
        if ({starve, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL loop_starve_ovf: got %b, expected 00", {starve, ovf});
        end
    endtask

    task automatic test_audit();
        word_t w;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            load_word(1'b0, '0, 1'b0, w);
            checks++;
            if ($countones(error) != int'(nerr)) begin
                errors++;
                $display("FAIL audit_popcount: got %0d, expected %0d", $countones(error), nerr);
            end
            checks++;
            if (int'(nerr) > T) begin
                errors++;
                $display("FAIL audit_nerr_range: got %0d, expected <= %0d", nerr, T);
            end
            ticks(nxt.len + 2);
        end
    endtask

    task automatic test_starve_ovf();
        word_t w;
        logic [K-1:0] d;
        do_reset();
        load_req = 1'b1;
        ticks(60);
        load_req = 1'b0;
        checks++;
        if (starve !== 1'b1) begin
            errors++;
            $display("FAIL starve: got %0b, expected 1", starve);
        end

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(1'b0, '0, 1'b0, w);
            ticks(nxt.len + 2);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_full: got %0b, expected 0", ovf);
        end
        load_word(1'b0, '0, 1'b0, w);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %0b, expected 1", ovf);
        end
        checks++;
        if (starve !== 1'b0) begin
            errors++;
            $display("FAIL ovf_no_starve: got %0b, expected 0", starve);
        end

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(1'b0, '0, 1'b0, w);
            sent_q.push_back(w.d);
            ticks(nxt.len + 2);
        end
        d = sent_q.pop_front();
        load_word(1'b1, d, 1'b0, w);
        sent_q.push_back(w.d);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_push_pop_full: got %0b, expected 0", ovf);
        end
        while (sent_q.size() > 0) begin
            d = sent_q.pop_front();
            send_vdout(d, 1'b0);
        end
        send_vdout('0, 1'b1);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_after_drain: got %0b, expected 0", ovf);
        end
    endtask

    task automatic test_reset_mid();
        word_t w;
        bit found;
        found = 1'b0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            load_word(1'b0, '0, 1'b0, w);
            if (nxt.ne != 0) begin
                found = 1'b1;
                break;
            end
            ticks(nxt.len + 2);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_setup: got no word with nerr>0, expected one within 50");
        end
        ticks(nxt.pre);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({din, nerr, error, wrong_now, wrong, starve, ovf, frames, mismatches} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got din=%0h nerr=%0d error=%0h, expected all 0",
                     din, nerr, error);
        end
        ticks(2);
        reset = 1'b0;
        m_lfsr = SEED;
        m_gen(nxt);
        ticks(nxt.len + 2);
        load_word(1'b0, '0, 1'b0, w);
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_loopback(100, -1);
        test_loopback(10, 4);
        test_audit();
        test_starve_ovf();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
